// File: rtl/ps2_command_queue.sv
// PS/2 keyboard receiver: decodes make-codes into 3-bit game commands and queues
// them for the game logic behind a ready/read_fin handshake.
module ps2_command_queue #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int QUEUE_DEPTH    = 4,
    parameter int CMD_WIDTH      = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ps2_clock,
    input  logic                 ps2_data,
    input  logic                 read_fin,
    output logic                 ready,
    output logic [CMD_WIDTH-1:0] data,
    output logic                 frame_err,
    output logic                 overflow
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    logic clk_s1, clk_s2, dat_s1, dat_s2, fin_s1, fin_s2, fin_prev;
    logic             filt_clk;
    logic [FLT_W-1:0] filt_cnt;
    logic             ps2_fall;
    logic             ps2_bit;

    rx_state_t        state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic [TMO_W-1:0] timer;
    logic [7:0]       rx_byte;
    logic             byte_valid;

    logic                 ext, brk;
    logic [2:0]           mapped;
    logic                 push_req;
    logic [CMD_WIDTH-1:0] push_cmd;

    logic [CMD_WIDTH-1:0] mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, next_rd;
    logic [CNT_W-1:0]     count, remaining, next_count;
    logic                 pop_req, do_pop, do_push;
    logic [CMD_WIDTH-1:0] next_head;

    always_ff @(posedge clock) begin
        if (reset) begin
            {clk_s1, clk_s2, dat_s1, dat_s2, fin_s1, fin_s2, fin_prev} <= '0;
        end else begin
            clk_s1   <= ps2_clock;
            clk_s2   <= clk_s1;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
            fin_s1   <= read_fin;
            fin_s2   <= fin_s1;
            fin_prev <= fin_s2;
        end
    end

    // The data bit is captured in the same cycle the filtered clock is seen to fall.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt_clk <= 1'b0;
            filt_cnt <= '0;
            ps2_fall <= 1'b0;
            ps2_bit  <= 1'b0;
        end else begin
            ps2_fall <= 1'b0;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
                ps2_fall <= filt_clk;
                ps2_bit  <= dat_s2;
            end else begin
                filt_cnt <= filt_cnt + FLT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            timer      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            timer      <= (state == IDLE || ps2_fall) ? '0 : timer + TMO_W'(1);
            if (state != IDLE && !ps2_fall && timer == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end else if (ps2_fall) begin
                case (state)
                    IDLE: begin
                        if (!ps2_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {ps2_bit, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        if (^{shift_reg, ps2_bit}) begin
                            state <= STOP;
                        end else begin
                            state     <= IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                    STOP: begin
                        state <= IDLE;
                        if (ps2_bit) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shift_reg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Arrow keys count only with the E0 prefix; the same codes alone are keypad keys.
    function automatic logic [2:0] map_code(input logic [7:0] code, input logic is_ext);
        logic [2:0] cmd;
        cmd = 3'd0;
        case (code)
            8'h1D: cmd = 3'd1;
            8'h1B: cmd = 3'd2;
            8'h1C: cmd = 3'd3;
            8'h23: cmd = 3'd4;
            8'h29: cmd = 3'd5;
            8'h5A: cmd = is_ext ? 3'd0 : 3'd6;
            8'h75: cmd = is_ext ? 3'd1 : 3'd0;
            8'h72: cmd = is_ext ? 3'd2 : 3'd0;
            8'h6B: cmd = is_ext ? 3'd3 : 3'd0;
            8'h74: cmd = is_ext ? 3'd4 : 3'd0;
            default: cmd = 3'd0;
        endcase
        return cmd;
    endfunction

    always_comb begin
        mapped   = map_code(rx_byte, ext);
        push_cmd = CMD_WIDTH'(mapped);
        push_req = byte_valid && rx_byte != 8'hE0 && rx_byte != 8'hF0 && !brk && mapped != 3'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == 8'hE0) begin
                ext <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    always_comb begin
        pop_req    = fin_s2 & ~fin_prev;
        do_pop     = pop_req && (count != '0);
        do_push    = push_req && ((count != CNT_W'(QUEUE_DEPTH)) || do_pop);
        remaining  = count - CNT_W'(do_pop);
        next_count = remaining + CNT_W'(do_push);
        next_rd    = rd_ptr + PTR_W'(do_pop);
        if (remaining == '0) next_head = do_push ? push_cmd : '0;
        else                 next_head = mem[next_rd];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready    <= 1'b0;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_cmd;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr   <= next_rd;
            count    <= next_count;
            ready    <= (next_count != '0);
            data     <= next_head;
            overflow <= push_req && !do_push;
        end
    end
endmodule

// File: tb/tb_ps2_command_queue.sv
// Directed bench for ps2_command_queue: sends PS/2 frames and read_fin pulses and
// checks ready/data each settled cycle against a queue-level model of the command FIFO.
module tb_ps2_command_queue;
    localparam int HALF  = 10;
    localparam int TMO   = 300;
    localparam int DEPTH = 4;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       ps2_clock = 1'b1;
    logic       ps2_data  = 1'b1;
    logic       read_fin  = 1'b0;
    logic       ready;
    logic [2:0] data;
    logic       frame_err;
    logic       overflow;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    bit exp_ext     = 1'b0;
    bit exp_brk     = 1'b0;
    int exp_err     = 0;
    int exp_ovf     = 0;
    int err_seen    = 0;
    int ovf_seen    = 0;
    bit check_en    = 1'b0;

    ps2_command_queue #(
        .FILTER_LEN(4),
        .TIMEOUT_CYCLES(TMO),
        .QUEUE_DEPTH(DEPTH),
        .CMD_WIDTH(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clock(ps2_clock),
        .ps2_data(ps2_data),
        .read_fin(read_fin),
        .ready(ready),
        .data(data),
        .frame_err(frame_err),
        .overflow(overflow)
    );

    initial forever #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_err) err_seen++;
        if (overflow) ovf_seen++;
    end

    task automatic checkLiteral(input string name, input logic [31:0] actual, input int expected);
        vectors++;
        if (actual !== 32'(expected)) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        int exp_ready;
        int exp_data;
        exp_ready = (exp_q.size() != 0) ? 1 : 0;
        exp_data  = (exp_q.size() != 0) ? exp_q[0] : 0;
        checkLiteral("ready", {31'b0, ready}, exp_ready);
        checkLiteral("data", {29'b0, data}, exp_data);
    endtask

    task automatic checkCounters();
        checkLiteral("frame_err_count", err_seen, exp_err);
        checkLiteral("overflow_count", ovf_seen, exp_ovf);
    endtask

    task automatic cycle();
        @(posedge clock);
        #2;
        if (check_en) checkOutput();
    endtask

    task automatic waitCycles(input int n);
        repeat (n) cycle();
    endtask

    function automatic int cmdOf(input bit ext, input logic [7:0] code);
        if (code == 8'h1D || (ext && code == 8'h75)) return 1;
        if (code == 8'h1B || (ext && code == 8'h72)) return 2;
        if (code == 8'h1C || (ext && code == 8'h6B)) return 3;
        if (code == 8'h23 || (ext && code == 8'h74)) return 4;
        if (code == 8'h29) return 5;
        if (code == 8'h5A && !ext) return 6;
        return 0;
    endfunction

    task automatic modelByte(input logic [7:0] code);
        int c;
        if (code == 8'hE0) begin
            exp_ext = 1'b1;
        end else if (code == 8'hF0) begin
            exp_brk = 1'b1;
        end else begin
            c = exp_brk ? 0 : cmdOf(exp_ext, code);
            if (c != 0) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(c);
                else exp_ovf++;
            end
            exp_ext = 1'b0;
            exp_brk = 1'b0;
        end
    endtask

    task automatic modelPop();
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic sendBit(input logic b);
        ps2_data = b;
        waitCycles(HALF);
        ps2_clock = 1'b0;
        waitCycles(HALF);
        ps2_clock = 1'b1;
    endtask

    // pop_delay >= 0 raises read_fin that many cycles after the stop-bit clock falls.
    task automatic applyStimulus(input logic [7:0] code, input bit bad_parity, input int pop_delay);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(code[i]);
        sendBit(~^code ^ bad_parity);
        check_en = 1'b0;
        ps2_data = 1'b1;
        waitCycles(HALF);
        ps2_clock = 1'b0;
        if (pop_delay >= 0) begin
            waitCycles(pop_delay);
            read_fin = 1'b1;
            waitCycles(HALF - pop_delay);
        end else begin
            waitCycles(HALF);
        end
        ps2_clock = 1'b1;
        waitCycles(6);
        read_fin = 1'b0;
        if (pop_delay >= 0) modelPop();
        if (bad_parity) exp_err++;
        else modelByte(code);
        waitCycles(4);
        check_en = 1'b1;
    endtask

    task automatic sendCode(input logic [7:0] code);
        applyStimulus(code, 1'b0, -1);
    endtask

    task automatic popPulse();
        check_en = 1'b0;
        read_fin = 1'b1;
        waitCycles(6);
        read_fin = 1'b0;
        waitCycles(3);
        modelPop();
        check_en = 1'b1;
    endtask

    task automatic applyReset();
        check_en = 1'b0;
        reset    = 1'b1;
        read_fin = 1'b0;
        waitCycles(3);
        reset = 1'b0;
        exp_q.delete();
        exp_ext = 1'b0;
        exp_brk = 1'b0;
        waitCycles(12);
        check_en = 1'b1;
    endtask

    initial begin
        waitCycles(3);
        checkLiteral("reset_ready", {31'b0, ready}, 0);
        checkLiteral("reset_data", {29'b0, data}, 0);
        checkLiteral("reset_frame_err", {31'b0, frame_err}, 0);
        checkLiteral("reset_overflow", {31'b0, overflow}, 0);
        reset = 1'b0;
        waitCycles(12);
        check_en = 1'b1;

        $display("[TB] single W frame and pop latency");
        sendCode(8'h1D);
        checkLiteral("w_ready", {31'b0, ready}, 1);
        checkLiteral("w_data", {29'b0, data}, 1);
        check_en = 1'b0;
        read_fin = 1'b1;
        waitCycles(2);
        checkLiteral("ready_before_pop", {31'b0, ready}, 1);
        waitCycles(1);
        checkLiteral("ready_after_pop", {31'b0, ready}, 0);
        read_fin = 1'b0;
        modelPop();
        waitCycles(3);
        check_en = 1'b1;

        $display("[TB] extended make, break and keypad codes");
        sendCode(8'hE0); sendCode(8'h74);
        sendCode(8'hE0); sendCode(8'hF0); sendCode(8'h74);
        sendCode(8'h75);
        sendCode(8'h15);
        checkLiteral("ext_right_data", {29'b0, data}, 4);
        checkLiteral("ext_queue_size", exp_q.size(), 1);
        popPulse();
        checkLiteral("ext_drained", {31'b0, ready}, 0);

        $display("[TB] parity error then enter");
        applyStimulus(8'h29, 1'b1, -1);
        checkCounters();
        checkLiteral("bad_parity_ready", {31'b0, ready}, 0);
        sendCode(8'h5A);
        checkLiteral("enter_data", {29'b0, data}, 6);
        popPulse();

        $display("[TB] overflow and drain");
        sendCode(8'h1C); sendCode(8'h1B); sendCode(8'h23); sendCode(8'h29); sendCode(8'h5A);
        checkCounters();
        checkLiteral("overflow_pulses", ovf_seen, 1);
        checkLiteral("drain_0", {29'b0, data}, 3); popPulse();
        checkLiteral("drain_1", {29'b0, data}, 2); popPulse();
        checkLiteral("drain_2", {29'b0, data}, 4); popPulse();
        checkLiteral("drain_3", {29'b0, data}, 5); popPulse();
        checkLiteral("drained_ready", {31'b0, ready}, 0);
        popPulse();

        $display("[TB] frame timeout");
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(1'b1);
        waitCycles(TMO - 50);
        checkLiteral("no_early_timeout", err_seen, exp_err);
        waitCycles(90);
        exp_err++;
        checkCounters();
        sendCode(8'h1C);
        checkLiteral("after_timeout_data", {29'b0, data}, 3);

        $display("[TB] simultaneous push and pop");
        sendCode(8'h1B);
        checkLiteral("pre_sim_size", exp_q.size(), 2);
        applyStimulus(8'h23, 1'b0, 5);
        checkLiteral("sim_size", exp_q.size(), 2);
        checkLiteral("sim_head", {29'b0, data}, 2);
        popPulse();
        checkLiteral("sim_tail", {29'b0, data}, 4);
        popPulse();

        $display("[TB] read_fin held high");
        sendCode(8'h1D); sendCode(8'h1B);
        check_en = 1'b0;
        read_fin = 1'b1;
        waitCycles(4);
        modelPop();
        check_en = 1'b1;
        waitCycles(30);
        read_fin = 1'b0;
        waitCycles(3);
        checkLiteral("held_data", {29'b0, data}, 2);
        popPulse();

        $display("[TB] reset mid-frame");
        sendCode(8'h29);
        sendCode(8'hE0);
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        applyReset();
        checkLiteral("reset_mid_ready", {31'b0, ready}, 0);
        sendCode(8'h72);
        sendCode(8'h5A);
        checkLiteral("post_reset_data", {29'b0, data}, 6);
        checkCounters();
        popPulse();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
